// File: rtl/spi_master_engine_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master engine and the clock-division stage
// upstream of it.
//   - spi_state_t : engine FSM states (IDLE, SETUP, TRANSFER, DONE)
//   - calc_half   : system clocks per SCLK half-period
//   - DEFAULT_*   : default frequencies and word width
// ----------------------------------------------------------------------------
package spi_pkg;

    localparam int DEFAULT_CLK_IN_FREQ = 100_000_000;
    localparam int DEFAULT_SCLK_FREQ   = 200_000;
    localparam int DEFAULT_DATA_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        DONE     = 2'd3
    } spi_state_t;

    // Number of clk_in cycles in one SCLK half-period.
    function automatic int calc_half(input int clk_in_freq, input int sclk_freq);
        return clk_in_freq / (2 * sclk_freq);
    endfunction

endpackage

// File: rtl/spi_master_engine_if.sv
// ----------------------------------------------------------------------------
// spi_master_engine_if
// Transmit/receive handshake plus SPI pins of the master engine.
//   tx_data/tx_valid/tx_ready : word in. A word is accepted in any cycle where
//                               tx_valid && tx_ready; tx_valid while tx_ready
//                               is low is ignored and nothing is buffered.
//   rx_data/rx_valid          : word out, rx_valid is a one-cycle pulse with no
//                               back-pressure; rx_data holds until the next one.
//   sclk/mosi/cs_n/miso       : SPI mode 0 pins.
// Modports: master = engine side, slave = user/pin side.
// ----------------------------------------------------------------------------
interface spi_master_engine_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    modport master (
        input  tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, sclk, mosi, cs_n
    );

    modport slave (
        output tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_engine_edge_tick.sv
// ----------------------------------------------------------------------------
// spi_edge_tick
// Half-period counter. While enabled, o_tick is high for one cycle every HALF
// cycles, first after HALF-1 cycles of enable. Cleared when disabled or reset.
//   clk_in   : system clock
//   rst      : synchronous active-high reset
//   i_enable : count enable
//   o_tick   : one-cycle half-period tick
// ----------------------------------------------------------------------------
module spi_edge_tick
    import spi_pkg::*;
#(
    parameter int HALF = 1
) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_enable,
    output logic o_tick
);
    localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_in) begin
        if (rst || !i_enable) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = i_enable && (r_count == LAST);
endmodule

// File: rtl/spi_master_engine.sv
// ----------------------------------------------------------------------------
// spi_master_engine
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, single clock
// domain. SCLK is a registered output toggled by a half-period tick.
//   clk_in      : system clock
//   rst         : synchronous active-high reset
//   bus         : spi_master_engine_if.master (handshake + SPI pins)
//   o_dbg_state : current FSM state
// Build option: SPI_LOOPBACK_EN - RX shifter samples the registered mosi
// instead of the miso pin (board self-test).
// ----------------------------------------------------------------------------
module spi_master_engine
    import spi_pkg::*;
#(
    parameter int CLK_IN_FREQ = DEFAULT_CLK_IN_FREQ,
    parameter int SCLK_FREQ   = DEFAULT_SCLK_FREQ,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
    input  logic                clk_in,
    input  logic                rst,
    spi_master_engine_if.master bus,
    output spi_state_t          o_dbg_state
);
    localparam int            HALF     = calc_half(CLK_IN_FREQ, SCLK_FREQ);
    localparam int            BW       = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);

    if (HALF < 1) begin : g_half_check
        $fatal(1, "spi_master_engine: SCLK_FREQ too high for CLK_IN_FREQ");
    end

    spi_state_t            r_state,    w_state_nxt;
    logic [DATA_WIDTH-1:0] r_tx_sr,    w_tx_sr_nxt;
    logic [DATA_WIDTH-1:0] r_rx_sr,    w_rx_sr_nxt;
    logic [BW-1:0]         r_bit_cnt,  w_bit_cnt_nxt;
    logic                  r_sclk,     w_sclk_nxt;
    logic                  r_mosi,     w_mosi_nxt;
    logic                  r_cs_n,     w_cs_n_nxt;
    logic                  r_tx_ready, w_tx_ready_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data,  w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;

    logic                  w_tick;
    logic                  w_accept;
    logic                  w_rx_bit;
    logic [DATA_WIDTH-1:0] w_tx_shift;
    logic [DATA_WIDTH-1:0] w_rx_shift;

    // Counter restarts from zero on accept, so the first tick lands exactly
    // HALF cycles after cs_n falls.
    spi_edge_tick #(.HALF(HALF)) u_edge_tick (
        .clk_in   (clk_in),
        .rst      (rst),
        .i_enable (r_state != IDLE),
        .o_tick   (w_tick)
    );

`ifdef SPI_LOOPBACK_EN
    assign w_rx_bit = r_mosi;
`else
    assign w_rx_bit = bus.miso;
`endif

    assign w_accept   = bus.tx_valid && r_tx_ready;
    assign w_tx_shift = r_tx_sr << 1;
    assign w_rx_shift = (r_rx_sr << 1) | DATA_WIDTH'(w_rx_bit);

    always_comb begin
        w_state_nxt    = r_state;
        w_tx_sr_nxt    = r_tx_sr;
        w_rx_sr_nxt    = r_rx_sr;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_cs_n_nxt     = r_cs_n;
        w_tx_ready_nxt = r_tx_ready;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = SETUP;
                    w_tx_sr_nxt    = bus.tx_data;
                    w_rx_sr_nxt    = '0;
                    w_bit_cnt_nxt  = '0;
                    w_cs_n_nxt     = 1'b0;
                    w_mosi_nxt     = bus.tx_data[DATA_WIDTH-1];
                    w_tx_ready_nxt = 1'b0;
                end
            end
            // The end of the CS setup time is also the first rising edge.
            SETUP: begin
                if (w_tick) begin
                    w_state_nxt = TRANSFER;
                    w_sclk_nxt  = 1'b1;
                    w_rx_sr_nxt = w_rx_shift;
                end
            end
            // A low half-period with all bits done is the one extra half-period
            // before the CS hold time starts.
            TRANSFER: begin
                if (w_tick) begin
                    if (r_sclk) begin
                        w_sclk_nxt    = 1'b0;
                        w_tx_sr_nxt   = w_tx_shift;
                        w_mosi_nxt    = w_tx_shift[DATA_WIDTH-1];
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end else if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_sclk_nxt  = 1'b1;
                        w_rx_sr_nxt = w_rx_shift;
                    end
                end
            end
            DONE: begin
                if (w_tick) begin
                    w_state_nxt    = IDLE;
                    w_cs_n_nxt     = 1'b1;
                    w_mosi_nxt     = 1'b0;
                    w_tx_ready_nxt = 1'b1;
                    w_rx_data_nxt  = r_rx_sr;
                    w_rx_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_tx_ready <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_sr    <= w_tx_sr_nxt;
            r_rx_sr    <= w_rx_sr_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.sclk     = r_sclk;
    assign bus.mosi     = r_mosi;
    assign bus.cs_n     = r_cs_n;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_spi_master_engine.sv
// ----------------------------------------------------------------------------
// tb_spi_master_engine
// Two engines share one clock: dut_d with default parameters (HALF=250) and
// dut_f with CLK_IN_FREQ=8, SCLK_FREQ=2 (HALF=2). Each has a mode-0 slave
// model that shifts its word out MSB first, changing on SCLK falls, and a
// monitor that records mosi at SCLK rises and the SCLK edge times.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_engine;
    import spi_pkg::*;

    localparam int CLK_P  = 10;
    localparam int W      = 8;
    localparam int HALF_D = 250;
    localparam int HALF_F = 2;
    localparam int LAT_D  = (2 * W + 2) * HALF_D + 1;
    localparam int LAT_F  = (2 * W + 2) * HALF_F + 1;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    always #(CLK_P / 2) clk_in = ~clk_in;

    spi_master_engine_if #(.DATA_WIDTH(W)) bus_d ();
    spi_master_engine_if #(.DATA_WIDTH(W)) bus_f ();
    spi_state_t dbg_d, dbg_f;

    spi_master_engine #(.DATA_WIDTH(W)) dut_d (
        .clk_in (clk_in), .rst (rst), .bus (bus_d), .o_dbg_state (dbg_d)
    );
    spi_master_engine #(.CLK_IN_FREQ(8), .SCLK_FREQ(2), .DATA_WIDTH(W)) dut_f (
        .clk_in (clk_in), .rst (rst), .bus (bus_f), .o_dbg_state (dbg_f)
    );

    // ---------------- slave models and monitors ----------------
    logic [W-1:0] slv_word_d = '0, slv_word_f = '0;
    int nfall_d = 0, base_d = 0, nfall_f = 0, base_f = 0;
    int rise_cnt_f = 0;
    longint rise_t_d = 0, prev_rise_t_d = 0, fall_t_d = 0;
    longint rise_t_f = 0, prev_rise_t_f = 0, fall_t_f = 0;
    logic mosi_q_d[$];
    logic mosi_q_f[$];

    function automatic logic slave_bit(input logic [W-1:0] word, input int idx);
        return (idx >= 0 && idx < W) ? word[W-1-idx] : 1'b0;
    endfunction

    always @(negedge bus_d.sclk) begin nfall_d = nfall_d + 1; fall_t_d = $time; end
    always @(negedge bus_d.cs_n) base_d = nfall_d;
    always @(posedge bus_d.sclk) begin
        prev_rise_t_d = rise_t_d; rise_t_d = $time; mosi_q_d.push_back(bus_d.mosi);
    end
    always @(negedge bus_f.sclk) begin nfall_f = nfall_f + 1; fall_t_f = $time; end
    always @(negedge bus_f.cs_n) base_f = nfall_f;
    always @(posedge bus_f.sclk) begin
        prev_rise_t_f = rise_t_f; rise_t_f = $time; rise_cnt_f = rise_cnt_f + 1;
        mosi_q_f.push_back(bus_f.mosi);
    end

`ifdef SPI_LOOPBACK_EN
    assign bus_d.miso = 1'b0;
    assign bus_f.miso = 1'b0;
`else
    assign bus_d.miso = slave_bit(slv_word_d, nfall_d - base_d);
    assign bus_f.miso = slave_bit(slv_word_f, nfall_f - base_f);
`endif

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_rx(input logic [W-1:0] tx, input logic [W-1:0] slv);
`ifdef SPI_LOOPBACK_EN
        return tx;
`else
        return slv;
`endif
    endfunction

    function automatic logic [W-1:0] pack_bits(input logic q[$]);
        logic [W-1:0] v = '0;
        foreach (q[i]) v = {v[W-2:0], q[i]};
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag, input bit fast);
        if (fast) begin
            check({tag, "_tx_ready"}, 32'(bus_f.tx_ready), 1);
            check({tag, "_rx_valid"}, 32'(bus_f.rx_valid), 0);
            check({tag, "_rx_data"},  32'(bus_f.rx_data),  0);
            check({tag, "_sclk"},     32'(bus_f.sclk),     0);
            check({tag, "_mosi"},     32'(bus_f.mosi),     0);
            check({tag, "_cs_n"},     32'(bus_f.cs_n),     1);
        end else begin
            check({tag, "_tx_ready"}, 32'(bus_d.tx_ready), 1);
            check({tag, "_rx_valid"}, 32'(bus_d.rx_valid), 0);
            check({tag, "_rx_data"},  32'(bus_d.rx_data),  0);
            check({tag, "_sclk"},     32'(bus_d.sclk),     0);
            check({tag, "_mosi"},     32'(bus_d.mosi),     0);
            check({tag, "_cs_n"},     32'(bus_d.cs_n),     1);
        end
    endtask

    // ---------------- driver (fast engine) ----------------
    // Offers tx, waits for the accept edge, then counts cycles to rx_valid.
    // lat is the cycle number relative to the accept cycle T0.
    task automatic transfer_f(input logic [W-1:0] tx, input logic [W-1:0] slv,
                              output logic [W-1:0] rx, output int lat);
        int guard = 0;
        slv_word_f = slv;
        @(negedge clk_in);
        bus_f.tx_data  = tx;
        bus_f.tx_valid = 1'b1;
        while (!bus_f.tx_ready && guard < 200) begin @(negedge clk_in); guard++; end
        mosi_q_f.delete();
        @(posedge clk_in);
        @(negedge clk_in);
        bus_f.tx_valid = 1'b0;
        lat = 1;
        while (!bus_f.rx_valid && lat < 1000) begin @(negedge clk_in); lat++; end
        rx = bus_f.rx_data;
    endtask

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] slv;
        logic [W-1:0] exp_rx;
        int           exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] rx, tx, slv;
        int lat, cyc, guard;
        bit seen;

        vecs[0] = '{8'hFF, 8'h00, model_rx(8'hFF, 8'h00), LAT_F};
        vecs[1] = '{8'h00, 8'hFF, model_rx(8'h00, 8'hFF), LAT_F};
        vecs[2] = '{8'h5A, 8'hA5, model_rx(8'h5A, 8'hA5), LAT_F};
        vecs[3] = '{8'h81, 8'h7E, model_rx(8'h81, 8'h7E), LAT_F};
        vecs[4] = '{8'h01, 8'h80, model_rx(8'h01, 8'h80), LAT_F};
        vecs[5] = '{8'hC3, 8'h96, model_rx(8'hC3, 8'h96), LAT_F};

        bus_d.tx_valid = 1'b0; bus_d.tx_data = '0;
        bus_f.tx_valid = 1'b0; bus_f.tx_data = '0;

        // ---- power-up reset ----
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        check_reset_values("por_d", 1'b0);
        check_reset_values("por_f", 1'b1);

        // ---- default parameters: 0xA5 out, slave 0x3C ----
        slv_word_d = 8'h3C;
        mosi_q_d.delete();
        @(negedge clk_in);
        bus_d.tx_data  = 8'hA5;
        bus_d.tx_valid = 1'b1;
        check("d_ready_idle", 32'(bus_d.tx_ready), 1);
        @(posedge clk_in);
        @(negedge clk_in);
        bus_d.tx_valid = 1'b0;
        check("d_cs_fall", 32'(bus_d.cs_n), 0);
        check("d_ready_busy", 32'(bus_d.tx_ready), 0);
        lat = 1;
        while (!bus_d.rx_valid && lat < 6000) begin @(negedge clk_in); lat++; end
        check("d_latency", 32'(lat), 32'(LAT_D));
        check("d_rx_data", 32'(bus_d.rx_data), 32'(model_rx(8'hA5, 8'h3C)));
        check("d_ready_rxv", 32'(bus_d.tx_ready), 1);
        check("d_mosi_count", 32'(mosi_q_d.size()), 32'(W));
        check("d_mosi_bits", 32'(pack_bits(mosi_q_d)), 32'h A5);
        check("d_sclk_period", 32'((rise_t_d - prev_rise_t_d) / CLK_P), 32'(2 * HALF_D));
        check("d_sclk_high", 32'((fall_t_d - rise_t_d) / CLK_P), 32'(HALF_D));
        @(negedge clk_in);
        check("d_rx_valid_pulse", 32'(bus_d.rx_valid), 0);
        check("d_rx_hold", 32'(bus_d.rx_data), 32'(model_rx(8'hA5, 8'h3C)));

        // ---- fast parameters: table vectors ----
        for (int i = 0; i < 6; i++) begin
            transfer_f(vecs[i].tx, vecs[i].slv, rx, lat);
            check($sformatf("vec%0d_rx", i), 32'(rx), 32'(vecs[i].exp_rx));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_mosi", i), 32'(pack_bits(mosi_q_f)), 32'(vecs[i].tx));
            check($sformatf("vec%0d_period", i), 32'((rise_t_f - prev_rise_t_f) / CLK_P), 32'(2 * HALF_F));
        end

        // ---- fast parameters: random words ----
        for (int i = 0; i < 16; i++) begin
            tx  = W'($urandom_range(0, 255));
            slv = W'($urandom_range(0, 255));
            transfer_f(tx, slv, rx, lat);
            check($sformatf("rnd%0d_rx", i), 32'(rx), 32'(model_rx(tx, slv)));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(LAT_F));
            check($sformatf("rnd%0d_mosi", i), 32'(pack_bits(mosi_q_f)), 32'(tx));
        end

        // ---- busy handling: valid held with 0x11 then 0x22 ----
        slv_word_f = 8'h3C;
        @(negedge clk_in);
        bus_f.tx_data  = 8'h11;
        bus_f.tx_valid = 1'b1;
        check("busy_ready0", 32'(bus_f.tx_ready), 1);
        @(posedge clk_in);
        @(negedge clk_in);
        bus_f.tx_data = 8'h22;
        cyc = 1;
        while (!bus_f.tx_ready && cyc < 200) begin @(negedge clk_in); cyc++; end
        check("busy_ready_cycle", 32'(cyc), 32'(LAT_F));
        check("busy_accept_in_rxv", 32'(bus_f.rx_valid), 1);
        check("busy_rx1", 32'(bus_f.rx_data), 32'(model_rx(8'h11, 8'h3C)));
        check("busy_cs_high", 32'(bus_f.cs_n), 1);
        @(posedge clk_in);
        @(negedge clk_in);
        bus_f.tx_valid = 1'b0;
        check("busy_cs_low_again", 32'(bus_f.cs_n), 0);
        lat = 1;
        while (!bus_f.rx_valid && lat < 1000) begin @(negedge clk_in); lat++; end
        check("busy_lat2", 32'(lat), 32'(LAT_F));
        check("busy_rx2", 32'(bus_f.rx_data), 32'(model_rx(8'h22, 8'h3C)));

        // ---- 3-cycle reset mid-simulation ----
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        check_reset_values("rst_d", 1'b0);
        check_reset_values("rst_f", 1'b1);
        check("rst_state_f", 32'(dbg_f), 32'(IDLE));
        repeat (2) @(negedge clk_in);
        rst = 1'b0;

        // ---- reset after the 3rd sclk rise ----
        slv_word_f = 8'hE7;
        @(negedge clk_in);
        bus_f.tx_data  = 8'hB4;
        bus_f.tx_valid = 1'b1;
        guard = rise_cnt_f;
        @(posedge clk_in);
        @(negedge clk_in);
        bus_f.tx_valid = 1'b0;
        cyc = 0;
        while (rise_cnt_f - guard < 3 && cyc < 200) begin @(negedge clk_in); cyc++; end
        check("mid_third_rise", 32'(rise_cnt_f - guard), 3);
        rst = 1'b1;
        @(negedge clk_in);
        check("mid_cs_n", 32'(bus_f.cs_n), 1);
        check("mid_sclk", 32'(bus_f.sclk), 0);
        check("mid_ready", 32'(bus_f.tx_ready), 1);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_in);
            if (bus_f.rx_valid) seen = 1'b1;
        end
        check("mid_no_rx_valid", 32'(seen), 0);
        check("mid_rx_data", 32'(bus_f.rx_data), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #(CLK_P * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/spi_master_engine.md
# spi_master_engine

Byte-oriented SPI master (mode 0, CPOL=0/CPHA=0, MSB first). It sits directly downstream of the SPI clock-division stage and runs entirely in the `clk_in` domain. It does not use a derived clock; it generates SCLK from an internal half-period tick counter at the same divided rate. It accepts a transmit word over a valid/ready handshake, runs one chip-select-framed transfer, and returns the received word with a one-cycle valid pulse.

## Interface
- `CLK_IN_FREQ`, 100000000: input clock frequency, Hz.
- `SCLK_FREQ`, 200000: SPI SCLK frequency, Hz.
- `DATA_WIDTH`, 8: bits per transfer.
- `clk_in` input 1: system clock. One clock domain only.
- `rst` input 1: reset. Synchronous, active-high.
- `tx_data` input DATA_WIDTH: word to transmit.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: engine is idle and can accept a word.
- `rx_data` output DATA_WIDTH: last received word; held until the next transfer completes.
- `rx_valid` output 1: one-cycle pulse when `rx_data` is updated.
- `sclk` output 1: SPI clock.
- `mosi` output 1: master-out data.
- `miso` input 1: master-in data.
- `cs_n` output 1: active-low chip select.

## Operation
- HALF = CLK_IN_FREQ/(2*SCLK_FREQ).
  - Elaboration-time fatal error if HALF < 1.
  - Half-period counter width is max(1, $clog2(HALF)).
  - Bit counter width is $clog2(DATA_WIDTH+1).
- Accept: when `tx_valid && tx_ready`, latch `tx_data` into the TX shift register.
- States:
  - IDLE:
    - Outputs: `cs_n`=1, `sclk`=0, `tx_ready`=1, `mosi`=0.
    - On accept, go to SETUP. Next cycle drives `cs_n`=0 and `mosi`=tx MSB, and the counter clears.
  - SETUP:
    - Hold for HALF cycles (CS-to-first-edge setup), then go to TRANSFER.
  - TRANSFER:
    - `sclk` toggles every HALF cycles.
    - Rising edge: shift `miso` into the RX shift register (LSB in).
    - Falling edge: shift TX left, drive the next bit on `mosi`, increment the bit counter.
    - After DATA_WIDTH rising edges and the final falling edge, go to DONE with `sclk`=0.
  - DONE:
    - Hold `cs_n`=0 for HALF cycles (hold time).
    - Then go to IDLE: `cs_n`=1, `rx_data` ← RX shift register, `rx_valid`=1 for one cycle, `tx_ready`=1.
- `tx_valid` while not ready is ignored. The block never buffers more than one word.
- Back-to-back: a word may be accepted in the same cycle `rx_valid` is high. `cs_n` is then high for exactly one `clk_in` cycle between frames.
- `rst` at any state:
  - The next edge forces IDLE with `cs_n`=1, `sclk`=0, `mosi`=0, `rx_valid`=0, `rx_data`=0, and all counters at 0.
  - A partial transfer is discarded and produces no `rx_valid`.

## Timing
- Reset values: `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `sclk`=0, `mosi`=0, `cs_n`=1.
- Accept edge T0: `cs_n` falls at T0+1. First `sclk` rise occurs HALF cycles after `cs_n` falls.
- SCLK period is 2*HALF cycles at 50% duty. `mosi` is stable for HALF cycles before each rising edge.
- `rx_valid` is high in cycle T0+(2*DATA_WIDTH+2)*HALF+1.
  - Defaults: HALF=250, so `rx_valid` at T0+4501.
- `tx_ready` is low from T0+1 through the cycle before `rx_valid`, and high again in the `rx_valid` cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SPI_LOOPBACK_EN`:
  - Defined: the RX shifter samples the internally registered `mosi` instead of the `miso` pin, and `miso` is unused. This is for board self-test.
  - Undefined: the RX shifter samples `miso` normally, with no extra logic.

## Structure
- Package `spi_pkg`:
  - State enum `spi_state_t` (IDLE, SETUP, TRANSFER, DONE).
  - Function computing HALF from the frequencies.
  - Default frequency and width constants shared with the clock-division stage.
- One sub-module, `spi_edge_tick`: the half-period counter.
  - Input: enable.
  - Output: one-cycle `tick` every HALF cycles.
  - Cleared on enable low or `rst`.

## Test plan
- Reset: assert `rst` 3 cycles mid-simulation → all outputs at their reset values on the following edge.
- Transfer with defaults: `tx_data`=0xA5, slave model drives 0x3C.
  - `mosi` sampled on `sclk` rises reads 1,0,1,0,0,1,0,1.
  - `rx_data`=0x3C with `rx_valid` at T0+4501.
  - `sclk` period is 500 cycles.
- Fast parameters: CLK_IN_FREQ=8, SCLK_FREQ=2 (HALF=2), 0xFF out / 0x00 in.
  - `sclk` period is 4 cycles.
  - `rx_valid` at T0+37.
- Busy handling: hold `tx_valid` high with 0x11, then 0x22.
  - Second word accepted only in the `rx_valid` cycle of the first.
  - `cs_n` high for exactly 1 cycle between frames.
- Reset mid-transfer: assert `rst` after the 3rd `sclk` rise → `cs_n`=1 and `sclk`=0 next edge, no `rx_valid`, `rx_data` stays 0.
- Loopback (`SPI_LOOPBACK_EN` defined, `miso` tied 0): send 0x5A → `rx_data`=0x5A.
